pixel_scan_ctrl: RTL
====================

// Module: pixel_scan_ctrl
// PURPOSE
//  Sequencer between the image pixel memory and the filter datapath in main.
//  - On start: latches image size and filter code.
//  - Raster-scans addresses 0..N*N-1, one read at a time; forwards each returned 24-bit RGB pixel
//    to the filter with a valid/ready handshake and line-position flags.
//  - Pulses done when the whole frame has been accepted by the filter.
// PARAMETERS
//  ADDR_W   8   pixel address width (max frame 16x16 = 256 px)
//  PIX_W    24  pixel width, {R,G,B} 8 bits each
//  TIMEOUT  64  max cycles spent in WAIT for validData before abort (>=2)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       frame request, sampled in IDLE only
//  size         in   2       00=4x4, 01=8x8, 10=16x16, 11=illegal
//  filter       in   2       filter select, latched at start
//  rd_req       out  1       one-cycle read strobe to pixel memory
//  pixel_addr   out  ADDR_W  read address, valid while rd_req=1, held otherwise
//  validData    in   1       memory return strobe, pixel_in valid this cycle
//  pixel_in     in   PIX_W   returned pixel
//  fl_valid     out  1       pixel presented to filter
//  fl_ready     in   1       filter accepts when fl_valid&&fl_ready
//  fl_pixel     out  PIX_W   pixel to filter, stable while fl_valid=1
//  fl_mode      out  2       latched filter code, stable for whole frame
//  fl_sol       out  1       fl_pixel is column 0 of its row
//  fl_eol       out  1       fl_pixel is column N-1 of its row
//  fl_last      out  1       fl_pixel is last pixel of frame
//  busy         out  1       1 in any state but IDLE
//  done         out  1       one-cycle pulse, frame complete
//  err          out  1       one-cycle pulse, illegal size or read timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; pixel_addr=0; fl_mode=0; counters cleared.
//    Reset mid-frame aborts immediately; no done, no err.
//  Geometry: N = 4<<size; LAST = N*N-1 (15/63/255).
//    Column = pixel_addr[log2N-1:0]; row = pixel_addr>>log2N.
//  States:
//   IDLE: start&&size!=11 -> latch size, filter into fl_mode; pixel_addr=0 -> REQ.
//         start&&size==11 -> err pulse next cycle, stay IDLE.
//   REQ:  rd_req=1 for exactly one cycle -> WAIT; wait counter cleared.
//   WAIT: validData=1 -> capture pixel_in into fl_pixel; fl_valid=1; set sol/eol/last -> PUSH.
//         Counter reaches TIMEOUT with no validData -> err pulse -> IDLE, no done.
//   PUSH: hold fl_valid, fl_pixel and flags until fl_ready.
//         On accept: fl_valid=0 next cycle.
//         pixel_addr==LAST -> DONE; else pixel_addr+1 -> REQ.
//   DONE: done=1 for one cycle -> IDLE. fl_mode holds its value until the next start.
//  Throughput: 3 cycles/pixel minimum (REQ, WAIT with 1-cycle memory, PUSH with ready=1).
//  Ignored inputs:
//   - validData outside WAIT; start while busy.
//   - filter/size changes after start have no effect until the next frame.
//  pixel_addr never wraps: LAST is terminal.
//  Exactly one read outstanding. Exactly N*N filter beats per frame.
// TESTING
//  1. rst 2 cyc; start at cycle 0 with size=00, filter=10; memory returns validData 1 cycle
//     after rd_req; fl_ready=1.
//     -> 16 beats, addr 0..15; rd_req at cycles 1+3k; done only at cycle 49; fl_mode=10 throughout.
//  2. 8x8 frame -> fl_sol at addr 0,8,..,56; fl_eol at 7,15,..,63; fl_last only at 63;
//     64 beats, one done.
//  3. fl_ready low 5 cycles at beat 3 -> fl_pixel/flags stable; no new rd_req until accept;
//     no lost or duplicated pixel.
//  4. start with size=11 -> err pulse 1 cycle, busy stays 0, no rd_req.
//     Spurious validData in IDLE -> no fl_valid.
//  5. validData withheld after addr 5 read -> err after 64 WAIT cycles; IDLE, no done;
//     new start restarts at addr 0.
//  6. rst asserted in PUSH of 16x16 frame -> next cycle all outputs 0, IDLE; start while busy ignored.

Source files
------------

// File: rtl/pixel_scan_ctrl.sv
// pixel_scan_ctrl: raster-scan sequencer between the pixel memory and the filter datapath.
// Issues one memory read at a time, forwards each returned pixel to the filter over a
// valid/ready handshake with start/end-of-line and end-of-frame flags, and pulses done
// once the filter has accepted every pixel of the N x N frame.
module pixel_scan_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int PIX_W   = 24,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [1:0]        filter,
    output logic              rd_req,
    output logic [ADDR_W-1:0] pixel_addr,
    input  logic              validData,
    input  logic [PIX_W-1:0]  pixel_in,
    output logic              fl_valid,
    input  logic              fl_ready,
    output logic [PIX_W-1:0]  fl_pixel,
    output logic [1:0]        fl_mode,
    output logic              fl_sol,
    output logic              fl_eol,
    output logic              fl_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PUSH,
        S_DONE
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT);

    state_t            state_reg;
    logic [1:0]        size_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              rd_req_reg;
    logic [ADDR_W-1:0] pixel_addr_reg;
    logic              fl_valid_reg;
    logic [PIX_W-1:0]  fl_pixel_reg;
    logic [1:0]        fl_mode_reg;
    logic              fl_sol_reg;
    logic              fl_eol_reg;
    logic              fl_last_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;

    // Per-size geometry: last frame address (N*N-1) and column mask (N-1).
    // Entry 3 is never selected: an illegal size is rejected before it is latched.
    logic [ADDR_W-1:0] last_tbl     [4];
    logic [ADDR_W-1:0] col_mask_tbl [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_geom
            assign last_tbl[gi]     = ADDR_W'((1 << (2 * gi + 4)) - 1);
            assign col_mask_tbl[gi] = ADDR_W'((4 << gi) - 1);
        end
    endgenerate

    logic [ADDR_W-1:0] col_mask;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] col;

    assign col_mask  = col_mask_tbl[size_reg];
    assign last_addr = last_tbl[size_reg];
    assign col       = pixel_addr_reg & col_mask;

    // Frame sequencer: every output is a register updated on the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            size_reg       <= 2'b00;
            wait_cnt_reg   <= '0;
            rd_req_reg     <= 1'b0;
            pixel_addr_reg <= '0;
            fl_valid_reg   <= 1'b0;
            fl_pixel_reg   <= '0;
            fl_mode_reg    <= 2'b00;
            fl_sol_reg     <= 1'b0;
            fl_eol_reg     <= 1'b0;
            fl_last_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            rd_req_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (size != 2'b11) begin
                            size_reg       <= size;
                            fl_mode_reg    <= filter;
                            pixel_addr_reg <= '0;
                            rd_req_reg     <= 1'b1;
                            busy_reg       <= 1'b1;
                            state_reg      <= S_REQ;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    if (validData) begin
                        fl_pixel_reg <= pixel_in;
                        fl_valid_reg <= 1'b1;
                        fl_sol_reg   <= (col == '0);
                        fl_eol_reg   <= (col == col_mask);
                        fl_last_reg  <= (pixel_addr_reg == last_addr);
                        state_reg    <= S_PUSH;
                    end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        // Memory never answered: abandon the frame without done.
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                S_PUSH: begin
                    if (fl_ready) begin
                        fl_valid_reg <= 1'b0;
                        if (fl_last_reg) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            pixel_addr_reg <= pixel_addr_reg + 1'b1;
                            rd_req_reg     <= 1'b1;
                            state_reg      <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_req     = rd_req_reg;
    assign pixel_addr = pixel_addr_reg;
    assign fl_valid   = fl_valid_reg;
    assign fl_pixel   = fl_pixel_reg;
    assign fl_mode    = fl_mode_reg;
    assign fl_sol     = fl_sol_reg;
    assign fl_eol     = fl_eol_reg;
    assign fl_last    = fl_last_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;

endmodule
